// File: rtl/dcm_clkfx_model_if.sv
// Phase-shift port of the counter-based DCM model.
// The requester drives PSEN/PSINCDEC; the DCM returns PSDONE and STATUS.
interface dcm_clkfx_model_if;
    logic       PSEN;
    logic       PSINCDEC;
    logic       PSDONE;
    logic [7:0] STATUS;

    modport master (
        output PSEN,
        output PSINCDEC,
        input  PSDONE,
        input  STATUS
    );

    modport slave (
        input  PSEN,
        input  PSINCDEC,
        output PSDONE,
        output STATUS
    );
endinterface

// File: rtl/dcm_clkfx_model.sv
// Single-domain DCM emulation: every output clock is a registered square
// wave built from counters running on CLKIN, which acts as an oversampler.
module dcm_clkfx_model #(
    parameter int    REF_DIV               = 8,
    parameter int    CLKFX_MULTIPLY        = 4,
    parameter int    CLKFX_DIVIDE          = 2,
    parameter int    CLKDV_DIVIDE          = 2,
    parameter int    LOCK_CYCLES           = 16,
    parameter int    PS_MAX                = 2,
    parameter string DLL_FREQUENCY_MODE    = "HIGH",
    parameter string DUTY_CYCLE_CORRECTION = "TRUE",
    parameter string STARTUP_WAIT          = "FALSE",
    parameter string CLK_FEEDBACK          = "NONE"
) (
    input  logic CLKIN,
    input  logic RSTn,
    input  logic CLKFB,
    input  logic DSSEN,
    input  logic PSCLK,
    dcm_clkfx_model_if.slave ps,
    output logic CLK0,
    output logic CLK90,
    output logic CLK180,
    output logic CLK270,
    output logic CLK2X,
    output logic CLK2X180,
    output logic CLKDV,
    output logic CLKFX,
    output logic CLKFX180,
    output logic LOCKED
);
    localparam int N0  = REF_DIV;
    localparam int H   = REF_DIV / 2;
    localparam int Q   = REF_DIV / 4;
    localparam int NDV = REF_DIV * CLKDV_DIVIDE;
    localparam int NFX = REF_DIV * CLKFX_DIVIDE;
    localparam int PW  = $clog2(N0);
    localparam int DW  = $clog2(NDV);
    localparam int AW  = $clog2(NFX + CLKFX_MULTIPLY);
    localparam int LW  = $clog2(LOCK_CYCLES + 1);

    localparam logic [PW:0] OFF_MAX = (PW+1)'(PS_MAX);
    localparam logic [PW:0] OFF_MIN = (PW+1)'(-PS_MAX);

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_WAIT,
        PS_DONE
    } ps_state_t;

    ps_state_t      state;
    ps_state_t      state_nxt;
    logic           accept;

    logic [LW-1:0]  lock_cnt;
    logic [PW-1:0]  ph;
    logic [DW-1:0]  dv;
    logic [AW-1:0]  acc;
    logic [PW:0]    off;
    logic           ovf;
    logic           done;

    logic [PW-1:0]  ph_nxt;
    logic [DW-1:0]  dv_nxt;
    logic [AW-1:0]  acc_sum;
    logic [AW-1:0]  acc_nxt;
    logic [PW+1:0]  diff;
    logic [PW-1:0]  ps_ph;
    logic [PW-1:0]  ps_q;
    logic [PW-1:0]  ps_h;
    logic [PW:0]    off_nxt;
    logic           off_hit;

    wire unused_inputs = &{CLKFB, DSSEN, PSCLK,
                           DLL_FREQUENCY_MODE == "HIGH",
                           DUTY_CYCLE_CORRECTION == "TRUE",
                           STARTUP_WAIT == "FALSE",
                           CLK_FEEDBACK == "NONE"};

    always_comb begin
        ph_nxt  = (ph == PW'(N0 - 1)) ? '0 : ph + 1'b1;
        dv_nxt  = (dv == DW'(NDV - 1)) ? '0 : dv + 1'b1;
        acc_sum = acc + AW'(CLKFX_MULTIPLY);
        acc_nxt = (acc_sum >= AW'(NFX)) ? acc_sum - AW'(NFX) : acc_sum;
    end

    // Phase-shifted phase: (ph - off) wrapped into [0, REF_DIV)
    always_comb begin
        diff  = {2'b00, ph} - {off[PW], off};
        ps_ph = diff[PW+1] ? PW'(diff + (PW+2)'(N0)) : diff[PW-1:0];
        ps_q  = (ps_ph >= PW'(Q)) ? ps_ph - PW'(Q) : ps_ph + PW'(N0 - Q);
        ps_h  = (ps_ph >= PW'(H)) ? ps_ph - PW'(H) : ps_ph;
    end

    always_comb begin
        off_nxt = ps.PSINCDEC ? off + 1'b1 : off - 1'b1;
        off_hit = ps.PSINCDEC ? (off == OFF_MAX) : (off == OFF_MIN);
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            PS_IDLE: begin
                if (LOCKED && ps.PSEN) begin
                    accept    = 1'b1;
                    state_nxt = PS_WAIT;
                end
            end
            PS_WAIT: state_nxt = PS_DONE;
            PS_DONE: state_nxt = PS_IDLE;
            default: state_nxt = PS_IDLE;
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (!RSTn) begin
            state <= PS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (!RSTn) begin
            lock_cnt <= '0;
            LOCKED   <= 1'b0;
            ph       <= '0;
            dv       <= '0;
            acc      <= '0;
            off      <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            CLK0     <= 1'b0;
            CLK90    <= 1'b0;
            CLK180   <= 1'b0;
            CLK270   <= 1'b0;
            CLK2X    <= 1'b0;
            CLK2X180 <= 1'b0;
            CLKDV    <= 1'b0;
            CLKFX    <= 1'b0;
            CLKFX180 <= 1'b0;
        end else begin
            done <= (state == PS_DONE);
            if (!LOCKED) begin
                lock_cnt <= lock_cnt + 1'b1;
                if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                    LOCKED <= 1'b1;
                end
            end else begin
                ph       <= ph_nxt;
                dv       <= dv_nxt;
                acc      <= acc_nxt;
                CLK0     <= (ps_ph < PW'(H));
                CLK180   <= ~(ps_ph < PW'(H));
                CLK90    <= (ps_q < PW'(H));
                CLK270   <= ~(ps_q < PW'(H));
                CLK2X    <= (ps_h < PW'(Q));
                CLK2X180 <= ~(ps_h < PW'(Q));
                CLKDV    <= (dv < DW'(NDV / 2));
                CLKFX    <= (acc < AW'(NFX / 2));
                CLKFX180 <= ~(acc < AW'(NFX / 2));
            end
            if (accept) begin
                if (off_hit) begin
                    ovf <= 1'b1;
                end else begin
                    off <= off_nxt;
                    ovf <= 1'b0;
                end
            end
        end
    end

    assign ps.PSDONE = done;
    assign ps.STATUS = {7'b0, ovf};
endmodule

// File: tb/tb_dcm_clkfx_model.sv
// Directed bench for dcm_clkfx_model: lock, waveforms, phase shift, reset.
module tb_dcm_clkfx_model;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic c0, c90, c180, c270, c2x, c2x180, cdv, cfx, cfx180, locked;
    int tests = 0;
    int fails = 0;
    int lk = 0;

    always #5 clk = ~clk;

    dcm_clkfx_model_if psif();

    dcm_clkfx_model dut (
        .CLKIN(clk), .RSTn(rstn), .CLKFB(1'b0), .DSSEN(1'b0),
        .PSCLK(1'b0), .ps(psif.slave),
        .CLK0(c0), .CLK90(c90), .CLK180(c180), .CLK270(c270),
        .CLK2X(c2x), .CLK2X180(c2x180), .CLKDV(cdv),
        .CLKFX(cfx), .CLKFX180(cfx180), .LOCKED(locked)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {c0, c90, c180, c270, c2x, c2x180, cdv, cfx, cfx180,
                psif.PSDONE};
    endfunction

    // lk = edges taken while locked, i.e. the phase counters' value
    task automatic step();
        logic pre;
        pre = locked;
        @(posedge clk);
        #1;
        if (!rstn) lk = 0;
        else if (pre) lk++;
    endtask

    task automatic check_phase(string tag, int off);
        for (int i = 0; i < 8; i++) begin
            int p;
            logic e0, e90, e2x, edv, efx;
            p   = ((lk - off) % 8 + 8) % 8;
            e0  = (p < 4);
            e90 = (((p + 6) % 8) < 4);
            e2x = ((p % 4) < 2);
            edv = ((lk % 16) < 8);
            efx = ((lk % 4) < 2);
            step();
            check(tag, {c0, c180, c90, c270, c2x, c2x180, cdv, cfx, cfx180},
                  {e0, ~e0, e90, ~e90, e2x, ~e2x, edv, efx, ~efx});
        end
    endtask

    task automatic ps_step(logic inc, logic [7:0] exp_status);
        psif.PSEN = 1'b1;
        psif.PSINCDEC = inc;
        step();
        psif.PSEN = 1'b0;
        check("psdone_e0", psif.PSDONE, 0);
        step();
        check("psdone_e1", psif.PSDONE, 0);
        step();
        check("psdone_e2", psif.PSDONE, 1);
        step();
        check("psdone_e3", psif.PSDONE, 0);
        check("ps_status", psif.STATUS, exp_status);
    endtask

    initial begin
        logic [15:0] v0, v90, v180, v270, v2x, v2x180, vdv, vfx, vfx180;
        logic [5:0] pd;
        psif.PSEN = 1'b0;
        psif.PSINCDEC = 1'b0;
        rstn = 1'b0;
        repeat (3) step();
        check("reset_outs", outs(), 0);
        check("reset_locked", locked, 0);
        check("reset_status", psif.STATUS, 0);

        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("lock_wait", {locked, outs()}, {(k == 16), 10'd0});
        end

        for (int i = 0; i < 16; i++) begin
            step();
            v0 = {v0[14:0], c0};
            v90 = {v90[14:0], c90};
            v180 = {v180[14:0], c180};
            v270 = {v270[14:0], c270};
            v2x = {v2x[14:0], c2x};
            v2x180 = {v2x180[14:0], c2x180};
            vdv = {vdv[14:0], cdv};
            vfx = {vfx[14:0], cfx};
            vfx180 = {vfx180[14:0], cfx180};
        end
        check("clk0_pat", v0, 16'hF0F0);
        check("clk90_pat", v90, 16'h3C3C);
        check("clk180_pat", v180, 16'h0F0F);
        check("clk270_pat", v270, 16'hC3C3);
        check("clk2x_pat", v2x, 16'hCCCC);
        check("clk2x180_pat", v2x180, 16'h3333);
        check("clkdv_pat", vdv, 16'hFF00);
        check("clkfx_pat", vfx, 16'hCCCC);
        check("clkfx180_pat", vfx180, 16'h3333);

        ps_step(1'b1, 8'h00);
        check_phase("shift_p1", 1);
        ps_step(1'b0, 8'h00);
        check_phase("shift_0", 0);

        ps_step(1'b1, 8'h00);
        ps_step(1'b1, 8'h00);
        ps_step(1'b1, 8'h01);
        check_phase("ovf_hold", 2);
        ps_step(1'b0, 8'h00);
        check_phase("after_dec", 1);

        psif.PSEN = 1'b1;
        psif.PSINCDEC = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            pd = {pd[4:0], psif.PSDONE};
        end
        psif.PSEN = 1'b0;
        check("held_psdone", pd, 6'b001001);
        check("held_status", psif.STATUS, 8'h01);
        check_phase("held_phase", 2);

        rstn = 1'b0;
        step();
        check("midrst_outs", outs(), 0);
        check("midrst_locked", locked, 0);
        check("midrst_status", psif.STATUS, 0);
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            psif.PSEN = (k <= 3);
            step();
            check("relock_wait", {locked, outs()}, {(k == 16), 10'd0});
        end
        psif.PSEN = 1'b0;
        check_phase("relock_phase", 0);
        check("relock_status", psif.STATUS, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
